// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared declarations for the single-clock parametrised FIFO:
//   addr_w()        - address width for a given depth ($clog2)
//   fifo_err_t      - sticky error flag pair (ovf = write while full,
//                     udf = read while empty)
//   FIFO_MIN_DEPTH  - smallest legal DEPTH
// Optional feature macro used by the top level: SYNC_FIFO_FWFT_EN
// -----------------------------------------------------------------------------
package fifo_pkg;

  localparam int FIFO_MIN_DEPTH = 2;

  typedef struct packed {
    logic ovf;
    logic udf;
  } fifo_err_t;

  // Address width needed to index 'depth' entries.
  function automatic int addr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage : fifo_pkg

// File: rtl/fifo_mem.sv
// -----------------------------------------------------------------------------
// fifo_mem
// DEPTH x DATA_W flop array with one synchronous write port and one
// asynchronous read port. Contents are intentionally not reset.
// Ports:
//   clk    in   clock, rising edge
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data
//   raddr  in   read address
//   rdata  out  read data (combinational from raddr)
// -----------------------------------------------------------------------------
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                      clk,
  input  logic                      we,
  input  logic [addr_w(DEPTH)-1:0]  waddr,
  input  logic [DATA_W-1:0]         wdata,
  input  logic [addr_w(DEPTH)-1:0]  raddr,
  output logic [DATA_W-1:0]         rdata
);

  logic [DATA_W-1:0] mem_r [DEPTH];

  // Storage write port; no reset so the array maps onto plain flops.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule : fifo_mem

// File: rtl/sync_fifo_param.sv
// -----------------------------------------------------------------------------
// sync_fifo_param
// Single-clock FIFO with generic width/depth, occupancy count, programmable
// almost-full / almost-empty flags and sticky overflow / underflow flags.
// Ports:
//   clk      in   clock, rising edge
//   rst      in   asynchronous active-high reset (release synchronous to clk)
//   wData    in   write data
//   winc     in   write request
//   wFull    out  FIFO full
//   wAFull   out  count >= AF_LEVEL
//   rinc     in   read request
//   rData    out  read data
//   rEmpty   out  FIFO empty
//   rAEmpty  out  count <= AE_LEVEL
//   count    out  occupancy 0..DEPTH
//   errClr   in   clears sticky error flags
//   wOvf     out  sticky: write attempted while full
//   rUdf     out  sticky: read attempted while empty
// Optional feature macro: SYNC_FIFO_FWFT_EN
//   defined   - first-word-fall-through: rData shows the head entry whenever
//               rEmpty is low
//   undefined - registered read: rData updates on an accepted read and holds
// -----------------------------------------------------------------------------
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_W-1:0]        wData,
  input  logic                     winc,
  output logic                     wFull,
  output logic                     wAFull,
  input  logic                     rinc,
  output logic [DATA_W-1:0]        rData,
  output logic                     rEmpty,
  output logic                     rAEmpty,
  output logic [$clog2(DEPTH):0]   count,
  input  logic                     errClr,
  output logic                     wOvf,
  output logic                     rUdf
);

  localparam int ADDR_W = addr_w(DEPTH);
  localparam int PTR_W  = ADDR_W + 1;
  localparam int CNT_W  = ADDR_W + 1;

  localparam logic [CNT_W-1:0] AF_LVL_C = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0] AE_LVL_C = CNT_W'(AE_LEVEL);

  // Parameter legality, checked at elaboration.
  if ((DEPTH < FIFO_MIN_DEPTH) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $fatal(1, "sync_fifo_param: DEPTH must be a power of 2 and >= 2");
  end
  if ((AE_LEVEL < 0) || (AE_LEVEL >= AF_LEVEL) || (AF_LEVEL > DEPTH)) begin : g_bad_levels
    $fatal(1, "sync_fifo_param: require 0 <= AE_LEVEL < AF_LEVEL <= DEPTH");
  end

  // Pointers carry one extra wrap bit above the address bits.
  logic [PTR_W-1:0]  wptr_r;
  logic [PTR_W-1:0]  rptr_r;
  logic [PTR_W-1:0]  wptr_nxt_s;
  logic [PTR_W-1:0]  rptr_nxt_s;
  logic [CNT_W-1:0]  count_r;
  logic [CNT_W-1:0]  count_nxt_s;
  logic              full_r;
  logic              empty_r;
  logic              afull_r;
  logic              aempty_r;
  logic              full_nxt_s;
  logic              empty_nxt_s;
  logic              afull_nxt_s;
  logic              aempty_nxt_s;
  fifo_err_t         err_r;
  fifo_err_t         err_nxt_s;
  logic              wr_acc_s;
  logic              rd_acc_s;
  logic [DATA_W-1:0] mem_rdata_s;

  // Request acceptance uses only the registered flags, so a simultaneous
  // read/write while full or empty resolves against the cycle-start state.
  always_comb begin
    wr_acc_s = winc & ~full_r;
    rd_acc_s = rinc & ~empty_r;
  end

  // Next-state computation for pointers, count, flags and sticky errors.
  always_comb begin
    wptr_nxt_s   = wptr_r;
    rptr_nxt_s   = rptr_r;
    count_nxt_s  = count_r;
    err_nxt_s    = err_r;

    if (wr_acc_s) begin
      wptr_nxt_s = wptr_r + PTR_W'(1);
    end else begin
      wptr_nxt_s = wptr_r;
    end

    if (rd_acc_s) begin
      rptr_nxt_s = rptr_r + PTR_W'(1);
    end else begin
      rptr_nxt_s = rptr_r;
    end

    case ({wr_acc_s, rd_acc_s})
      2'b10:   count_nxt_s = count_r + CNT_W'(1);
      2'b01:   count_nxt_s = count_r - CNT_W'(1);
      default: count_nxt_s = count_r;
    endcase

    // A new error wins over a clear in the same cycle.
    err_nxt_s.ovf = (winc & full_r)  | (err_r.ovf & ~errClr);
    err_nxt_s.udf = (rinc & empty_r) | (err_r.udf & ~errClr);

    full_nxt_s   = (wptr_nxt_s[ADDR_W-1:0] == rptr_nxt_s[ADDR_W-1:0]) &&
                   (wptr_nxt_s[ADDR_W] != rptr_nxt_s[ADDR_W]);
    empty_nxt_s  = (wptr_nxt_s == rptr_nxt_s);
    afull_nxt_s  = (count_nxt_s >= AF_LVL_C);
    aempty_nxt_s = (count_nxt_s <= AE_LVL_C);
  end

  // State register: pointers, count, decoded flags and sticky errors.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_r   <= '0;
      rptr_r   <= '0;
      count_r  <= '0;
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
      afull_r  <= 1'b0;
      aempty_r <= 1'b1;
      err_r    <= '0;
    end else begin
      wptr_r   <= wptr_nxt_s;
      rptr_r   <= rptr_nxt_s;
      count_r  <= count_nxt_s;
      full_r   <= full_nxt_s;
      empty_r  <= empty_nxt_s;
      afull_r  <= afull_nxt_s;
      aempty_r <= aempty_nxt_s;
      err_r    <= err_nxt_s;
    end
  end

  fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (wr_acc_s),
    .waddr (wptr_r[ADDR_W-1:0]),
    .wdata (wData),
    .raddr (rptr_r[ADDR_W-1:0]),
    .rdata (mem_rdata_s)
  );

`ifdef SYNC_FIFO_FWFT_EN
  // Head entry is always on the read port; popping advances rptr and the
  // next entry appears as soon as the pointer register updates.
  assign rData = mem_rdata_s;
`else
  logic [DATA_W-1:0] rdata_r;

  // Registered read data: captured on an accepted read, held otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_r <= '0;
    end else if (rd_acc_s) begin
      rdata_r <= mem_rdata_s;
    end else begin
      rdata_r <= rdata_r;
    end
  end

  assign rData = rdata_r;
`endif

  assign wFull   = full_r;
  assign wAFull  = afull_r;
  assign rEmpty  = empty_r;
  assign rAEmpty = aempty_r;
  assign count   = count_r;
  assign wOvf    = err_r.ovf;
  assign rUdf    = err_r.udf;

endmodule : sync_fifo_param

// File: tb/tb_sync_fifo_param.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo_param
// Self-checking bench for sync_fifo_param (DATA_W=8, DEPTH=16, AF_LEVEL=12,
// AE_LEVEL=2). A queue-based reference model tracks contents, occupancy and
// sticky error flags; every cycle all DUT outputs are compared against it.
// Honours SYNC_FIFO_FWFT_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_sync_fifo_param;

  localparam int DW  = 8;
  localparam int DP  = 16;
  localparam int AFL = 12;
  localparam int AEL = 2;

  logic          clk;
  logic          rst;
  logic [DW-1:0] wData;
  logic          winc;
  logic          wFull;
  logic          wAFull;
  logic          rinc;
  logic [DW-1:0] rData;
  logic          rEmpty;
  logic          rAEmpty;
  logic [4:0]    count;
  logic          errClr;
  logic          wOvf;
  logic          rUdf;

  sync_fifo_param #(
    .DATA_W   (DW),
    .DEPTH    (DP),
    .AF_LEVEL (AFL),
    .AE_LEVEL (AEL)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .wData   (wData),
    .winc    (winc),
    .wFull   (wFull),
    .wAFull  (wAFull),
    .rinc    (rinc),
    .rData   (rData),
    .rEmpty  (rEmpty),
    .rAEmpty (rAEmpty),
    .count   (count),
    .errClr  (errClr),
    .wOvf    (wOvf),
    .rUdf    (rUdf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [DW-1:0] q[$];
  logic          m_ovf;
  logic          m_udf;
  logic [DW-1:0] m_rd;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("count",   32'(count),   32'(q.size()));
    chk("rEmpty",  32'(rEmpty),  32'(q.size() == 0));
    chk("wFull",   32'(wFull),   32'(q.size() == DP));
    chk("wAFull",  32'(wAFull),  32'(q.size() >= AFL));
    chk("rAEmpty", 32'(rAEmpty), 32'(q.size() <= AEL));
    chk("wOvf",    32'(wOvf),    32'(m_ovf));
    chk("rUdf",    32'(rUdf),    32'(m_udf));
`ifdef SYNC_FIFO_FWFT_EN
    if (q.size() > 0) chk("rData_head", 32'(rData), 32'(q[0]));
`else
    chk("rData", 32'(rData), 32'(m_rd));
`endif
  endtask

  // One clock cycle: drive at negedge, advance model, check after posedge.
  task automatic step(input logic w, input logic r, input logic [DW-1:0] d, input logic clr);
    bit was_full;
    bit was_empty;
    @(negedge clk);
    winc = w; rinc = r; wData = d; errClr = clr;
    was_full  = (q.size() == DP);
    was_empty = (q.size() == 0);
    m_ovf = (w && was_full)  || (m_ovf && !clr);
    m_udf = (r && was_empty) || (m_udf && !clr);
    if (r && !was_empty) m_rd = q.pop_front();
    if (w && !was_full)  q.push_back(d);
    @(posedge clk);
    #1;
    check_all();
  endtask

  // Asynchronous reset pulse, checked before any clock edge arrives.
  task automatic do_reset();
    @(negedge clk);
    winc = 1'b0; rinc = 1'b0; errClr = 1'b0;
    #2 rst = 1'b1;
    #1;
    q.delete();
    m_ovf = 1'b0; m_udf = 1'b0; m_rd = '0;
    check_all();
    chk("rst_rData", 32'(rData), 32'h0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; winc = 1'b0; rinc = 1'b0; wData = '0; errClr = 1'b0;
    q.delete(); m_ovf = 1'b0; m_udf = 1'b0; m_rd = '0;

    // 1. Reset, fill 0x00..0x0F, drain in order
    do_reset();
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, DW'(i), 1'b0);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, '0, 1'b0);
    chk("t1_end_count", 32'(count), 32'd0);

    // 2. Full + simultaneous write/read: write rejected, wOvf set, then clear
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, DW'($urandom), 1'b0);
    step(1'b1, 1'b1, 8'hEE, 1'b0);
    chk("t2_count15", 32'(count), 32'd15);
    chk("t2_ovf", 32'(wOvf), 32'd1);
    step(1'b0, 1'b0, '0, 1'b1);
    step(1'b1, 1'b0, 8'h77, 1'b0);
    step(1'b1, 1'b0, 8'h78, 1'b1);   // error and clear together: stays set
    step(1'b0, 1'b0, '0, 1'b1);

    // 3. Empty + simultaneous write/read: write accepted, rUdf set
    while (q.size() > 0) step(1'b0, 1'b1, '0, 1'b0);
    step(1'b1, 1'b1, 8'h5A, 1'b0);
    chk("t3_count1", 32'(count), 32'd1);
    chk("t3_udf", 32'(rUdf), 32'd1);
    step(1'b0, 1'b0, '0, 1'b1);

    // 4. Stream at count=8 for 40 cycles across several pointer wraps
    while (q.size() < 8) step(1'b1, 1'b0, DW'($urandom), 1'b0);
    for (int i = 0; i < 40; i++) step(1'b1, 1'b1, DW'($urandom), 1'b0);
    chk("t4_count8", 32'(count), 32'd8);

    // 5. Reset mid-burst discards contents
    while (q.size() > 0) step(1'b0, 1'b1, '0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, DW'(8'h10 + i), 1'b0);
    do_reset();
    step(1'b1, 1'b0, 8'hA5, 1'b0);
    chk("t5_count1", 32'(count), 32'd1);
    step(1'b0, 1'b1, '0, 1'b0);
`ifndef SYNC_FIFO_FWFT_EN
    chk("t5_rdA5", 32'(rData), 32'hA5);
`endif

`ifdef SYNC_FIFO_FWFT_EN
    // 6. FWFT: write shows on rData immediately, one pop empties
    step(1'b1, 1'b0, 8'h3C, 1'b0);
    chk("t6_fwft_data", 32'(rData), 32'h3C);
    step(1'b0, 1'b1, '0, 1'b0);
    chk("t6_empty", 32'(rEmpty), 32'd1);
`endif

    // Randomised traffic: write-heavy then read-heavy to hit both ends
    for (int i = 0; i < 300; i++) begin
      int wp;
      wp = (i < 150) ? 70 : 30;
      step(($urandom_range(0, 99) < wp), ($urandom_range(0, 99) < (100 - wp)),
           DW'($urandom), ($urandom_range(0, 15) == 0));
    end
    step(1'b0, 1'b0, '0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_sync_fifo_param
